sys_cmd_host: RTL and testbench
===============================

SYS_CMD_HOST -- requirements
Module: sys_cmd_host

Interface
REQ-001 Parameter: RSP_TIMEOUT, default 16'd1000; response timeout in CLK cycles, legal range 2..65535.
REQ-002 CLK  in  1  single clock; all logic rising-edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 CMD_VLD  in  1  command request.
REQ-005 CMD_RDY  out  1  command accepted when CMD_VLD && CMD_RDY.
REQ-006 CMD_OP  in  2  00 reg write, 01 reg read, 10 ALU with operands, 11 ALU no operands.
REQ-007 CMD_ADDR  in  4  register address.
REQ-008 CMD_DATA_A  in  8  write data, or ALU operand A.
REQ-009 CMD_DATA_B  in  8  ALU operand B.
REQ-010 CMD_FUN  in  4  ALU function code.
REQ-011 TX_P_DATA  out  8  byte to UART transmitter.
REQ-012 TX_D_VLD  out  1  byte valid; accepted when TX_D_VLD && !TX_BUSY.
REQ-013 TX_BUSY  in  1  transmitter busy.
REQ-014 RX_P_DATA  in  8  byte from UART receiver.
REQ-015 RX_D_VLD  in  1  single-cycle pulse, RX_P_DATA valid.
REQ-016 RSP_DATA  out  16  response payload.
REQ-017 RSP_VLD  out  1  one-cycle pulse, command complete.
REQ-018 TIMEOUT_ERR  out  1  one-cycle pulse, response not received in time.
REQ-019 BUSY  out  1  high whenever state != IDLE.

Function
REQ-020 States: IDLE, SEND, WAIT_RSP; one state register, registered outputs.
REQ-021 CMD_RDY = 1 only in IDLE; on accept, CMD_OP/ADDR/DATA_A/DATA_B/FUN latched, next state SEND, byte index = 0.
REQ-022 Frames, sent in order: write AA, {4'h0,ADDR}, DATA_A; read BB, {4'h0,ADDR}; ALU-op CC, DATA_A, DATA_B, {4'h0,FUN}; ALU-no-op DD, {4'h0,FUN}.
REQ-023 SEND: TX_D_VLD = 1 with TX_P_DATA = current frame byte, held stable until accepted; index advances only on acceptance.
REQ-024 TX_BUSY high holds the current byte indefinitely; no timeout applies in SEND.
REQ-025 Last byte accepted: write -> IDLE, RSP_VLD pulse next cycle, RSP_DATA = 16'h0000; read/ALU -> WAIT_RSP, TX_D_VLD = 0 next cycle.
REQ-026 Expected response bytes: read 1, ALU (either form) 2, LSB first.
REQ-027 Read response: RSP_DATA = {8'h00, byte}; ALU response: RSP_DATA = {byte1, byte0}.
REQ-028 RSP_VLD asserts the cycle after the final expected RX_D_VLD; state returns to IDLE in the same cycle.
REQ-029 Timeout counter (16-bit) clears on entry to WAIT_RSP and on every received byte; increments each WAIT_RSP cycle otherwise.
REQ-030 Counter reaching RSP_TIMEOUT-1 with no RX_D_VLD that cycle -> TIMEOUT_ERR pulse next cycle, IDLE, RSP_DATA unchanged, partial bytes discarded.
REQ-031 RX_D_VLD in the same cycle as timeout expiry: the byte wins, the counter clears, and no error is flagged.
REQ-032 RX_D_VLD outside WAIT_RSP is ignored without side effects.
REQ-033 RSP_VLD and TIMEOUT_ERR are never high in the same cycle.
REQ-034 CMD_RDY rises the cycle after RSP_VLD/TIMEOUT_ERR; a new command may be accepted that cycle.
REQ-035 Inputs CMD_* are ignored while BUSY; latched values are not affected by input changes.

Reset
REQ-036 RST high at a clock edge forces IDLE in any state, including mid-frame or mid-response; the pending command is dropped.
REQ-037 Reset values: CMD_RDY 1 (0 while RST is high), TX_D_VLD 0, TX_P_DATA 8'h00, RSP_DATA 16'h0000, RSP_VLD 0, TIMEOUT_ERR 0, BUSY 0, counter 0, index 0.

Verification
REQ-038 Write OP=00 ADDR=3 DATA_A=0x41, TX_BUSY=0 -> TX bytes AA,03,41 on consecutive cycles; RSP_VLD with 0x0000.
REQ-039 Read ADDR=2, TX_BUSY high 5 cycles on byte 1; RX 0x5A -> BB held 5 cycles, then 02; RSP_DATA=0x005A.
REQ-040 ALU-op A=0x10 B=0x20 FUN=1; RX 0x00 then 0x02 -> TX bytes CC,10,20,01; RSP_DATA=0x0200.
REQ-041 RSP_TIMEOUT=8, read, no RX -> TIMEOUT_ERR exactly 8 cycles after entering WAIT_RSP; RSP_VLD stays 0.
REQ-042 ALU-no-op FUN=2, RX byte0 at expiry cycle, byte1 three cycles later -> DD,02 sent; no TIMEOUT_ERR; RSP_VLD.
REQ-043 RST mid-frame (after byte 2 of CC frame) -> next cycle IDLE, TX_D_VLD 0; stray RX_D_VLD ignored.

Source files
------------

// File: rtl/sys_cmd_host.sv
// -----------------------------------------------------------------------------
// sys_cmd_host
//
// Turns a parallel command request into a short byte frame for a UART
// transmitter. For reads and ALU commands it then collects the response bytes
// from a UART receiver. A bounded wait guards the response phase.
//
// Frames (first byte is the header):
//   write      : AA, {0,ADDR}, DATA_A                    -> no response
//   read       : BB, {0,ADDR}                            -> 1 response byte
//   ALU op     : CC, DATA_A, DATA_B, {0,FUN}             -> 2 response bytes
//   ALU no-op  : DD, {0,FUN}                             -> 2 response bytes
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   CMD_VLD/CMD_RDY   command handshake (ready only when idle)
//   CMD_OP/ADDR/...   command fields, captured on acceptance
//   TX_P_DATA/TX_D_VLD/TX_BUSY  byte stream to transmitter (valid/!busy)
//   RX_P_DATA/RX_D_VLD          byte pulses from receiver
//   RSP_DATA/RSP_VLD  response payload and completion pulse
//   TIMEOUT_ERR       pulse when the response did not arrive in time
//   BUSY              high whenever a command is in progress
// -----------------------------------------------------------------------------
module sys_cmd_host #(
    parameter logic [15:0] RSP_TIMEOUT = 16'd1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VLD,
    output logic        CMD_RDY,
    input  logic [1:0]  CMD_OP,
    input  logic [3:0]  CMD_ADDR,
    input  logic [7:0]  CMD_DATA_A,
    input  logic [7:0]  CMD_DATA_B,
    input  logic [3:0]  CMD_FUN,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    input  logic        TX_BUSY,
    input  logic [7:0]  RX_P_DATA,
    input  logic        RX_D_VLD,
    output logic [15:0] RSP_DATA,
    output logic        RSP_VLD,
    output logic        TIMEOUT_ERR,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [15:0] TMO_LAST = RSP_TIMEOUT - 16'd1;

    // Byte at position idx of the frame for the given command.
    function automatic logic [7:0] frame_byte(
        input logic [1:0] op,
        input logic [3:0] addr,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [3:0] fun,
        input logic [1:0] idx
    );
        logic [7:0] byte_out;
        byte_out = 8'h00;
        case (op)
            OP_WR: begin
                case (idx)
                    2'd0:    byte_out = 8'hAA;
                    2'd1:    byte_out = {4'h0, addr};
                    2'd2:    byte_out = a;
                    default: byte_out = 8'h00;
                endcase
            end
            OP_RD: begin
                case (idx)
                    2'd0:    byte_out = 8'hBB;
                    2'd1:    byte_out = {4'h0, addr};
                    default: byte_out = 8'h00;
                endcase
            end
            OP_ALU: begin
                case (idx)
                    2'd0:    byte_out = 8'hCC;
                    2'd1:    byte_out = a;
                    2'd2:    byte_out = b;
                    default: byte_out = {4'h0, fun};
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    byte_out = 8'hDD;
                    2'd1:    byte_out = {4'h0, fun};
                    default: byte_out = 8'h00;
                endcase
            end
        endcase
        return byte_out;
    endfunction

    // Index of the final byte of the frame for the given command.
    function automatic logic [1:0] frame_last(input logic [1:0] op);
        logic [1:0] last;
        case (op)
            OP_WR:   last = 2'd2;
            OP_RD:   last = 2'd1;
            OP_ALU:  last = 2'd3;
            default: last = 2'd1;
        endcase
        return last;
    endfunction

    state_t      state_q, state_d;

    // Captured command
    logic [1:0]  op_q;
    logic [3:0]  addr_q;
    logic [7:0]  data_a_q;
    logic [7:0]  data_b_q;
    logic [3:0]  fun_q;

    // Sequencing and output registers
    logic        tx_vld_q,   tx_vld_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic [1:0]  tx_idx_q,   tx_idx_d;
    logic        rx_idx_q,   rx_idx_d;
    logic [7:0]  rx_byte0_q, rx_byte0_d;
    logic [15:0] tmo_cnt_q,  tmo_cnt_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_vld_q,  rsp_vld_d;
    logic        tmo_err_q,  tmo_err_d;

    logic        cmd_accept;
    logic        tx_accept;
    logic        tx_last;
    logic [1:0]  tx_idx_inc;
    logic        rx_take;
    logic        rx_last;
    logic        tmo_hit;

    // Ready is held off for the completion-pulse cycle so a new command
    // can only start the cycle after RSP_VLD / TIMEOUT_ERR.
    assign CMD_RDY     = (state_q == ST_IDLE) && !rsp_vld_q && !tmo_err_q && !RST;
    assign BUSY        = (state_q != ST_IDLE);
    assign TX_D_VLD    = tx_vld_q;
    assign TX_P_DATA   = tx_data_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_VLD     = rsp_vld_q;
    assign TIMEOUT_ERR = tmo_err_q;

    assign cmd_accept = CMD_VLD && CMD_RDY;
    assign tx_accept  = (state_q == ST_SEND) && tx_vld_q && !TX_BUSY;
    assign tx_last    = (tx_idx_q == frame_last(op_q));
    assign tx_idx_inc = tx_idx_q + 2'd1;
    assign rx_take    = (state_q == ST_WAIT_RSP) && RX_D_VLD;
    assign rx_last    = rx_take && ((op_q == OP_RD) || rx_idx_q);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign tmo_hit    = (state_q == ST_WAIT_RSP) && !RX_D_VLD && (tmo_cnt_q == TMO_LAST);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_accept && tx_last) begin
                    state_d = (op_q == OP_WR) ? ST_IDLE : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (rx_last || tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and sequencing counters
    always_comb begin
        tx_vld_d   = tx_vld_q;
        tx_data_d  = tx_data_q;
        tx_idx_d   = tx_idx_q;
        rx_idx_d   = rx_idx_q;
        rx_byte0_d = rx_byte0_q;
        tmo_cnt_d  = tmo_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_vld_d  = 1'b0;
        tmo_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    // Header depends only on the opcode, so it can be
                    // presented straight from the request fields.
                    tx_vld_d  = 1'b1;
                    tx_idx_d  = 2'd0;
                    tx_data_d = frame_byte(CMD_OP, CMD_ADDR, CMD_DATA_A,
                                           CMD_DATA_B, CMD_FUN, 2'd0);
                end
            end
            ST_SEND: begin
                if (tx_accept) begin
                    if (tx_last) begin
                        tx_vld_d = 1'b0;
                        tx_idx_d = 2'd0;
                        if (op_q == OP_WR) begin
                            rsp_vld_d  = 1'b1;
                            rsp_data_d = 16'h0000;
                        end else begin
                            tmo_cnt_d = 16'd0;
                            rx_idx_d  = 1'b0;
                        end
                    end else begin
                        tx_idx_d  = tx_idx_inc;
                        tx_data_d = frame_byte(op_q, addr_q, data_a_q,
                                               data_b_q, fun_q, tx_idx_inc);
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (rx_take) begin
                    tmo_cnt_d = 16'd0;
                    if (rx_last) begin
                        rsp_vld_d  = 1'b1;
                        rx_idx_d   = 1'b0;
                        rsp_data_d = (op_q == OP_RD) ? {8'h00, RX_P_DATA}
                                                     : {RX_P_DATA, rx_byte0_q};
                    end else begin
                        rx_byte0_d = RX_P_DATA;
                        rx_idx_d   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    // Any partially collected response is abandoned.
                    tmo_err_d = 1'b1;
                    tmo_cnt_d = 16'd0;
                    rx_idx_d  = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: begin
                tx_vld_d = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_vld_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_idx_q   <= 2'd0;
            rx_idx_q   <= 1'b0;
            tmo_cnt_q  <= 16'd0;
            rsp_data_q <= 16'h0000;
            rsp_vld_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            tx_vld_q   <= tx_vld_d;
            tx_data_q  <= tx_data_d;
            tx_idx_q   <= tx_idx_d;
            rx_idx_q   <= rx_idx_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    // Data registers: command capture and first response byte
    always_ff @(posedge CLK) begin
        rx_byte0_q <= rx_byte0_d;
        if (cmd_accept) begin
            op_q     <= CMD_OP;
            addr_q   <= CMD_ADDR;
            data_a_q <= CMD_DATA_A;
            data_b_q <= CMD_DATA_B;
            fun_q    <= CMD_FUN;
        end
    end

endmodule

// File: tb/tb_sys_cmd_host.sv
module tb_sys_cmd_host;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VLD;
    logic        CMD_RDY;
    logic [1:0]  CMD_OP;
    logic [3:0]  CMD_ADDR;
    logic [7:0]  CMD_DATA_A;
    logic [7:0]  CMD_DATA_B;
    logic [3:0]  CMD_FUN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        TIMEOUT_ERR;
    logic        BUSY;

    int n_chk = 0;
    int n_err = 0;

    sys_cmd_host #(.RSP_TIMEOUT(16'd8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CMD_VLD    (CMD_VLD),
        .CMD_RDY    (CMD_RDY),
        .CMD_OP     (CMD_OP),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_DATA_A (CMD_DATA_A),
        .CMD_DATA_B (CMD_DATA_B),
        .CMD_FUN    (CMD_FUN),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .TX_BUSY    (TX_BUSY),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .RSP_DATA   (RSP_DATA),
        .RSP_VLD    (RSP_VLD),
        .TIMEOUT_ERR(TIMEOUT_ERR),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present a command and return in the first cycle after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] addr,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] fun);
        int n;
        n = 0;
        while (!CMD_RDY && n < 20) begin
            step();
            n++;
        end
        chk("cmd_rdy_before_accept", CMD_RDY, 1);
        CMD_VLD    = 1'b1;
        CMD_OP     = op;
        CMD_ADDR   = addr;
        CMD_DATA_A = a;
        CMD_DATA_B = b;
        CMD_FUN    = fun;
        step();
        CMD_VLD = 1'b0;
        chk("busy_after_accept", BUSY, 1);
        chk("cmd_rdy_after_accept", CMD_RDY, 0);
    endtask

    // Check the byte on offer, then let one edge pass (accepts when !TX_BUSY).
    task automatic expect_tx(input string tag, input logic [7:0] b);
        chk({tag, "_vld"}, TX_D_VLD, 1);
        chk(tag, TX_P_DATA, b);
        step();
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        RX_D_VLD  = 1'b1;
        RX_P_DATA = b;
        step();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'h00;
    endtask

    initial begin
        RST        = 1'b1;
        CMD_VLD    = 1'b0;
        CMD_OP     = 2'b00;
        CMD_ADDR   = 4'h0;
        CMD_DATA_A = 8'h00;
        CMD_DATA_B = 8'h00;
        CMD_FUN    = 4'h0;
        TX_BUSY    = 1'b0;
        RX_P_DATA  = 8'h00;
        RX_D_VLD   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_cmd_rdy", CMD_RDY, 0);
        chk("rst_tx_vld", TX_D_VLD, 0);
        chk("rst_tx_data", TX_P_DATA, 8'h00);
        chk("rst_rsp_data", RSP_DATA, 16'h0000);
        chk("rst_rsp_vld", RSP_VLD, 0);
        chk("rst_tmo", TIMEOUT_ERR, 0);
        chk("rst_busy", BUSY, 0);
        RST = 1'b0;
        step();
        chk("idle_cmd_rdy", CMD_RDY, 1);

        // Read with transmitter stalled on the header byte
        TX_BUSY = 1'b1;
        send_cmd(2'b01, 4'h2, 8'h00, 8'h00, 4'h0);
        for (int i = 0; i < 5; i++) begin
            chk("rd_hold_vld", TX_D_VLD, 1);
            chk("rd_hold_bb", TX_P_DATA, 8'hBB);
            step();
        end
        TX_BUSY = 1'b0;
        expect_tx("rd_b0", 8'hBB);
        expect_tx("rd_b1", 8'h02);
        chk("rd_wait_txvld", TX_D_VLD, 0);
        chk("rd_wait_busy", BUSY, 1);
        rx_pulse(8'h5A);
        chk("rd_rsp_vld", RSP_VLD, 1);
        chk("rd_rsp_data", RSP_DATA, 16'h005A);
        chk("rd_rsp_tmo", TIMEOUT_ERR, 0);
        chk("rd_rsp_busy", BUSY, 0);
        chk("rd_rsp_rdy", CMD_RDY, 0);
        step();
        chk("rd_post_vld", RSP_VLD, 0);
        chk("rd_post_rdy", CMD_RDY, 1);

        // Write: three bytes back to back, immediate zero response
        send_cmd(2'b00, 4'h3, 8'h41, 8'h00, 4'h0);
        expect_tx("wr_b0", 8'hAA);
        expect_tx("wr_b1", 8'h03);
        expect_tx("wr_b2", 8'h41);
        chk("wr_txvld_off", TX_D_VLD, 0);
        chk("wr_rsp_vld", RSP_VLD, 1);
        chk("wr_rsp_data", RSP_DATA, 16'h0000);
        chk("wr_busy", BUSY, 0);
        chk("wr_rdy_pulse", CMD_RDY, 0);
        step();
        chk("wr_post_vld", RSP_VLD, 0);
        chk("wr_post_rdy", CMD_RDY, 1);

        // ALU with operands; request inputs wiggle while busy
        send_cmd(2'b10, 4'h0, 8'h10, 8'h20, 4'h1);
        CMD_VLD    = 1'b1;
        CMD_OP     = 2'b00;
        CMD_DATA_A = 8'hEE;
        CMD_DATA_B = 8'hFF;
        CMD_FUN    = 4'hF;
        expect_tx("alu_b0", 8'hCC);
        expect_tx("alu_b1", 8'h10);
        expect_tx("alu_b2", 8'h20);
        expect_tx("alu_b3", 8'h01);
        CMD_VLD = 1'b0;
        chk("alu_wait_txvld", TX_D_VLD, 0);
        rx_pulse(8'h00);
        chk("alu_mid_vld", RSP_VLD, 0);
        step();
        rx_pulse(8'h02);
        chk("alu_rsp_vld", RSP_VLD, 1);
        chk("alu_rsp_data", RSP_DATA, 16'h0200);
        step();

        // Read with no response: timeout exactly 8 cycles into the wait
        send_cmd(2'b01, 4'h5, 8'h00, 8'h00, 4'h0);
        expect_tx("to_b0", 8'hBB);
        expect_tx("to_b1", 8'h05);
        for (int k = 0; k < 8; k++) begin
            chk("to_early_tmo", TIMEOUT_ERR, 0);
            chk("to_early_busy", BUSY, 1);
            step();
        end
        chk("to_tmo", TIMEOUT_ERR, 1);
        chk("to_rsp_vld", RSP_VLD, 0);
        chk("to_rsp_keep", RSP_DATA, 16'h0200);
        chk("to_busy", BUSY, 0);
        chk("to_rdy_pulse", CMD_RDY, 0);
        step();
        chk("to_tmo_off", TIMEOUT_ERR, 0);
        chk("to_post_rdy", CMD_RDY, 1);

        // ALU no-op: first byte lands on the expiry cycle
        send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 4'h2);
        expect_tx("nop_b0", 8'hDD);
        expect_tx("nop_b1", 8'h02);
        for (int k = 0; k < 7; k++) step();
        chk("nop_pre_tmo", TIMEOUT_ERR, 0);
        rx_pulse(8'h34);
        chk("nop_expiry_tmo", TIMEOUT_ERR, 0);
        chk("nop_expiry_busy", BUSY, 1);
        step();
        chk("nop_w9_tmo", TIMEOUT_ERR, 0);
        step();
        rx_pulse(8'h12);
        chk("nop_rsp_vld", RSP_VLD, 1);
        chk("nop_rsp_data", RSP_DATA, 16'h1234);
        chk("nop_rsp_tmo", TIMEOUT_ERR, 0);
        step();

        // Reset in the middle of an ALU frame, then a stray receive pulse
        send_cmd(2'b10, 4'h0, 8'hAB, 8'hCD, 4'h7);
        expect_tx("mid_b0", 8'hCC);
        expect_tx("mid_b1", 8'hAB);
        chk("mid_b2", TX_P_DATA, 8'hCD);
        RST = 1'b1;
        step();
        chk("mid_rst_txvld", TX_D_VLD, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_txdata", TX_P_DATA, 8'h00);
        chk("mid_rst_rdy", CMD_RDY, 0);
        RST = 1'b0;
        rx_pulse(8'hEE);
        chk("stray_rsp_vld", RSP_VLD, 0);
        chk("stray_busy", BUSY, 0);
        chk("stray_rsp_data", RSP_DATA, 16'h0000);
        chk("stray_rdy", CMD_RDY, 1);
        step();
        chk("stray_txvld", TX_D_VLD, 0);

        // A following read still expects exactly one byte
        send_cmd(2'b01, 4'h9, 8'h00, 8'h00, 4'h0);
        expect_tx("rd2_b0", 8'hBB);
        expect_tx("rd2_b1", 8'h09);
        rx_pulse(8'h77);
        chk("rd2_rsp_vld", RSP_VLD, 1);
        chk("rd2_rsp_data", RSP_DATA, 16'h0077);
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
